// File: rtl/cpu_defs_pkg.sv
// Shared CPU control definitions: opcodes, FSM state encoding and opcode classification.
package cpu_defs_pkg;
    localparam int OP_W_DEF = 5;
    localparam int MEM_WAIT_DEF = 15;

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_SHR  = 5'b00101;
    localparam logic [4:0] OPC_SHL  = 5'b00110;
    localparam logic [4:0] OPC_ROR  = 5'b00111;
    localparam logic [4:0] OPC_ROL  = 5'b01000;
    localparam logic [4:0] OPC_AND  = 5'b01001;
    localparam logic [4:0] OPC_OR   = 5'b01010;
    localparam logic [4:0] OPC_ADDI = 5'b01011;
    localparam logic [4:0] OPC_ANDI = 5'b01100;
    localparam logic [4:0] OPC_ORI  = 5'b01101;
    localparam logic [4:0] OPC_MUL  = 5'b01110;
    localparam logic [4:0] OPC_DIV  = 5'b01111;
    localparam logic [4:0] OPC_NEG  = 5'b10000;
    localparam logic [4:0] OPC_NOT  = 5'b10001;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_JR   = 5'b10011;
    localparam logic [4:0] OPC_MFHI = 5'b10111;
    localparam logic [4:0] OPC_MFLO = 5'b11000;
    localparam logic [4:0] OPC_NOP  = 5'b11001;
    localparam logic [4:0] OPC_HALT = 5'b11010;

    localparam logic [4:0] OP_ADD = OPC_ADD;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_LD, C_LDI, C_ST, C_MULDIV, C_NEGNOT,
        C_BR, C_JR, C_MFHI, C_MFLO, C_HALT, C_NOP
    } op_class_t;

    // Undefined opcodes fall into C_NOP so they retire from T3 with no strobes.
    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t c;
        case (op)
            OPC_LD:                                   c = C_LD;
            OPC_LDI:                                  c = C_LDI;
            OPC_ST:                                   c = C_ST;
            OPC_ADD, OPC_SUB, OPC_SHR, OPC_SHL,
            OPC_ROR, OPC_ROL, OPC_AND, OPC_OR:        c = C_ALU;
            OPC_ADDI, OPC_ANDI, OPC_ORI:              c = C_IMM;
            OPC_MUL, OPC_DIV:                         c = C_MULDIV;
            OPC_NEG, OPC_NOT:                         c = C_NEGNOT;
            OPC_BR:                                   c = C_BR;
            OPC_JR:                                   c = C_JR;
            OPC_MFHI:                                 c = C_MFHI;
            OPC_MFLO:                                 c = C_MFLO;
            OPC_HALT:                                 c = C_HALT;
            default:                                  c = C_NOP;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has waited; expired flags the last permitted waiting cycle.
module mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    input  logic count,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            cnt <= '0;
        else if (restart)
            cnt <= '0;
        else if (count)
            cnt <= cnt + 1'b1;
    end

    // This waiting cycle is the one that brings the count to LIMIT.
    assign expired = count && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer: state-decoded strobes for the datapath and memory handshake.
module control_unit
    import cpu_defs_pkg::*;
#(
    parameter int         OP_W     = OP_W_DEF,
    parameter logic [4:0] OP_ADD_C = OP_ADD,
    parameter int         MEM_WAIT = MEM_WAIT_DEF
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [OP_W-1:0] ir_op,
    input  logic            con_ff,
    input  logic            mem_ready,
    output logic            pc_out, mdr_out, zlo_out, zhi_out, hi_out, lo_out, c_out,
    output logic            mar_in, pc_enable, pc_increment, ir_enable, y_enable,
    output logic            mdr_enable, mdr_read, zlo_enable, zhi_enable,
    output logic            lo_enable, hi_enable, con_enable,
    output logic            gra, grb, grc, r_in, r_out, ba_out,
    output logic [OP_W-1:0] op_code,
    output logic            mem_read,
    output logic            mem_write,
    output logic            run,
    output logic            fault
);
    state_t    state;
    op_class_t cls;
    logic      waiting, expired;

    assign cls = classify(ir_op[4:0]);
    assign waiting = (state == S_T1) || (state == S_T6 && cls == C_LD) || (state == S_T7 && cls == C_ST);

    mem_wait_timer #(.LIMIT(MEM_WAIT)) u_timer (
        .clk     (clk),
        .clr     (clr),
        .restart (!waiting),
        .count   (waiting && !mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_RST;
        end else begin
            case (state)
                S_RST: state <= S_T0;
                S_T0:  state <= S_T1;
                S_T1:  if (mem_ready) state <= S_T2; else if (expired) state <= S_FAULT;
                S_T2:  state <= S_T3;
                S_T3: begin
                    case (cls)
                        C_HALT:                     state <= S_HALT;
                        C_JR, C_MFHI, C_MFLO, C_NOP: state <= S_T0;
                        default:                    state <= S_T4;
                    endcase
                end
                S_T4:  state <= (cls == C_NEGNOT) ? S_T0 : S_T5;
                S_T5:  state <= (cls == C_ALU || cls == C_IMM || cls == C_LDI) ? S_T0 : S_T6;
                S_T6: begin
                    if (cls == C_LD) begin
                        if (mem_ready) state <= S_T7; else if (expired) state <= S_FAULT;
                    end else if (cls == C_ST) begin
                        state <= S_T7;
                    end else begin
                        state <= S_T0;
                    end
                end
                S_T7: begin
                    if (cls == C_ST) begin
                        if (mem_ready) state <= S_T0; else if (expired) state <= S_FAULT;
                    end else begin
                        state <= S_T0;
                    end
                end
                S_HALT:  state <= S_HALT;
                S_FAULT: state <= S_FAULT;
                default: state <= S_RST;
            endcase
        end
    end

    assign run   = !(state == S_RST || state == S_HALT || state == S_FAULT);
    assign fault = (state == S_FAULT);

    always_comb begin
        {pc_out, mdr_out, zlo_out, zhi_out, hi_out, lo_out, c_out} = '0;
        {mar_in, pc_enable, pc_increment, ir_enable, y_enable} = '0;
        {mdr_enable, mdr_read, zlo_enable, zhi_enable} = '0;
        {lo_enable, hi_enable, con_enable} = '0;
        {gra, grb, grc, r_in, r_out, ba_out} = '0;
        op_code   = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state)
            S_T0: begin pc_out = 1'b1; mar_in = 1'b1; pc_increment = 1'b1; end
            S_T1: begin
                mem_read = 1'b1;
                if (mem_ready) begin mdr_read = 1'b1; mdr_enable = 1'b1; end
            end
            S_T2: begin mdr_out = 1'b1; ir_enable = 1'b1; end
            S_T3: begin
                case (cls)
                    C_ALU, C_IMM:      begin grb = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
                    C_LD, C_LDI, C_ST: begin grb = 1'b1; r_out = 1'b1; ba_out = 1'b1; y_enable = 1'b1; end
                    C_MULDIV:          begin gra = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
                    C_NEGNOT:          begin grb = 1'b1; r_out = 1'b1; op_code = ir_op; zlo_enable = 1'b1; end
                    C_BR:              begin gra = 1'b1; r_out = 1'b1; con_enable = 1'b1; end
                    C_JR:              begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
                    C_MFHI:            begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    C_MFLO:            begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_ALU:             begin grc = 1'b1; r_out = 1'b1; op_code = ir_op; zlo_enable = 1'b1; end
                    C_IMM:             begin c_out = 1'b1; op_code = ir_op; zlo_enable = 1'b1; end
                    C_LD, C_LDI, C_ST: begin c_out = 1'b1; op_code = OP_W'(OP_ADD_C); zlo_enable = 1'b1; end
                    C_MULDIV: begin
                        grb = 1'b1; r_out = 1'b1; op_code = ir_op; zlo_enable = 1'b1; zhi_enable = 1'b1;
                    end
                    C_NEGNOT:          begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    C_BR:              begin pc_out = 1'b1; y_enable = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_ALU, C_IMM, C_LDI: begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    C_LD, C_ST:          begin zlo_out = 1'b1; mar_in = 1'b1; end
                    C_MULDIV:            begin zlo_out = 1'b1; lo_enable = 1'b1; end
                    C_BR:                begin c_out = 1'b1; op_code = OP_W'(OP_ADD_C); zlo_enable = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD: begin
                        mem_read = 1'b1;
                        if (mem_ready) begin mdr_read = 1'b1; mdr_enable = 1'b1; end
                    end
                    C_ST:     begin gra = 1'b1; r_out = 1'b1; mdr_enable = 1'b1; end
                    C_MULDIV: begin zhi_out = 1'b1; hi_enable = 1'b1; end
                    C_BR:     begin zlo_out = 1'b1; pc_enable = con_ff; end
                    default: ;
                endcase
            end
            S_T7: begin
                if (cls == C_LD) begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                else if (cls == C_ST) mem_write = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
